// File: rtl/conv_pkg.sv
// Shared types for the raster convolution window controller.
package conv_pkg;

    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_KERNEL_SIZE = 3;

    typedef logic signed [DEF_WORD_SIZE-1:0] pixel_t;
    typedef pixel_t [DEF_KERNEL_SIZE-1:0][DEF_KERNEL_SIZE-1:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: a circular RAM whose read and write share one pointer,
// so the word read is the one written IMG_WIDTH pushes earlier.
module conv_line_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int IMG_WIDTH = 640
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic signed [WORD_SIZE-1:0] i_wr_data,
    output logic signed [WORD_SIZE-1:0] o_rd_data
);

    localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(IMG_WIDTH - 1);

    logic signed [WORD_SIZE-1:0] r_mem [IMG_WIDTH];
    logic [PW-1:0]               r_ptr;

    // Pointer advances once per pushed pixel and wraps at the row length.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_push) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; stale rows are masked by the y gating upstream.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_ptr];

endmodule

// File: rtl/conv_window_controller.sv
// Streams raster pixels into a KxK window backed by K-1 line buffers, presents
// the window to an external combinational convolution, and registers its result
// once per fully-valid window position.
module conv_window_controller
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic signed [WORD_SIZE-1:0] pix_data,
    output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window,
    input  logic signed [WORD_SIZE-1:0] conv_ans,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WORD_SIZE-1:0] out_data,
    output logic [XW-1:0]               out_x,
    output logic [YW-1:0]               out_y,
    output logic                        busy,
    output logic                        done
);

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_FIRST_WIN = XW'(KERNEL_SIZE - 1);
    localparam logic [YW-1:0] Y_FIRST_WIN = YW'(KERNEL_SIZE - 1);

    ctrl_state_t                 r_state;
    logic [XW-1:0]               r_x;
    logic [YW-1:0]               r_y;
    logic                        r_frame_in_done;
    logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] r_window;
    logic                        r_win_valid;
    logic [XW-1:0]               r_tag_x;
    logic [YW-1:0]               r_tag_y;
    logic                        r_out_valid;
    logic signed [WORD_SIZE-1:0] r_out_data;
    logic [XW-1:0]               r_out_x;
    logic [YW-1:0]               r_out_y;
    logic                        r_done;

    logic                        w_advance;
    logic                        w_accept;
    logic                        w_last_xfer;
    logic signed [WORD_SIZE-1:0] w_tap    [KERNEL_SIZE];
    logic signed [WORD_SIZE-1:0] w_lb_out [KERNEL_SIZE-1];

    // The whole pipeline moves only when the output register is free or draining.
    assign w_advance   = !r_out_valid || out_ready;
    assign pix_ready   = (r_state == RUN) && w_advance && !r_frame_in_done;
    assign w_accept    = pix_valid && pix_ready;
    assign w_last_xfer = r_out_valid && out_ready && (r_out_x == X_LAST) && (r_out_y == Y_LAST);

    // Buffer 0 holds the previous row, buffer g the row g+1 above; window row r
    // therefore taps buffer K-2-r and the bottom row takes the live pixel.
    genvar g;
    generate
        for (g = 0; g < KERNEL_SIZE - 1; g++) begin : g_lb
            logic signed [WORD_SIZE-1:0] w_lb_in;
            if (g == 0) begin : g_head
                assign w_lb_in = pix_data;
            end else begin : g_chain
                assign w_lb_in = w_lb_out[g-1];
            end
            conv_line_buffer #(
                .WORD_SIZE(WORD_SIZE),
                .IMG_WIDTH(IMG_WIDTH)
            ) u_lb (
                .i_clk    (clk),
                .i_reset  (reset),
                .i_push   (w_accept),
                .i_wr_data(w_lb_in),
                .o_rd_data(w_lb_out[g])
            );
            assign w_tap[KERNEL_SIZE-2-g] = w_lb_out[g];
        end
    endgenerate
    assign w_tap[KERNEL_SIZE-1] = pix_data;

    // Frame FSM; done is a registered one-cycle pulse while in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) r_state <= RUN;
                end
                RUN: begin
                    if (w_last_xfer) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Raster position of the next pixel to accept; stops after the last pixel of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x             <= '0;
            r_y             <= '0;
            r_frame_in_done <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_x             <= '0;
            r_y             <= '0;
            r_frame_in_done <= 1'b0;
        end else if (w_accept) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST) r_frame_in_done <= 1'b1;
                else               r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Window shift: each row moves left and loads its tap into the rightmost column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_window[r][c] <= r_window[r][c+1];
                end
                r_window[r][KERNEL_SIZE-1] <= w_tap[r];
            end
        end
    end

    // Stage 1 marks complete windows; stage 2 captures the datapath result with its position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            r_tag_x     <= '0;
            r_tag_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else if (w_advance) begin
            r_win_valid <= w_accept && (r_x >= X_FIRST_WIN) && (r_y >= Y_FIRST_WIN);
            r_tag_x     <= r_x;
            r_tag_y     <= r_y;
            r_out_valid <= r_win_valid;
            r_out_data  <= conv_ans;
            r_out_x     <= r_tag_x;
            r_out_y     <= r_tag_y;
        end
    end

    assign window    = r_window;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_conv_window_controller.sv
// Bench for conv_window_controller: three instances (4x4, 5x3, 3x3 images)
// share one stimulus driver selected by 'sel'; a behavioural model computes
// expected outputs directly from the image and kernel.
module tb_conv_window_controller;

    localparam int K = 3;

    typedef logic signed [K-1:0][K-1:0][15:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start;
    logic               pix_valid;
    logic               out_ready;
    logic signed [15:0] pix_data;
    int                 sel;
    int                 kmode_a, kmode_b, kmode_c;

    // instance A: 4x4
    logic start_a, pv_a, pr_a, ov_a, busy_a, done_a;
    win_t win_a;
    logic signed [15:0] ans_a, od_a;
    logic [1:0] ox_a, oy_a;
    // instance B: 5x3
    logic start_b, pv_b, pr_b, ov_b, busy_b, done_b;
    win_t win_b;
    logic signed [15:0] ans_b, od_b;
    logic [2:0] ox_b;
    logic [1:0] oy_b;
    // instance C: 3x3
    logic start_c, pv_c, pr_c, ov_c, busy_c, done_c;
    win_t win_c;
    logic signed [15:0] ans_c, od_c;
    logic [1:0] ox_c, oy_c;

    // Kernel weight: mode 0 all ones, 1 centre only, 2 position-dependent (asymmetric).
    function automatic int kern_w(input int mode, input int i, input int j);
        if (mode == 0) return 1;
        if (mode == 1) return (i == 1 && j == 1) ? 1 : 0;
        return i * 3 + j + 1;
    endfunction

    // Combinational convolution datapath sitting beside each controller.
    function automatic logic signed [15:0] datapath(input win_t w, input int mode);
        int s;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += kern_w(mode, i, j) * int'($signed(w[i][j]));
        return 16'(s);
    endfunction

    assign ans_a = datapath(win_a, kmode_a);
    assign ans_b = datapath(win_b, kmode_b);
    assign ans_c = datapath(win_c, kmode_c);

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign pv_a    = pix_valid && (sel == 0);
    assign pv_b    = pix_valid && (sel == 1);
    assign pv_c    = pix_valid && (sel == 2);

    conv_window_controller #(.KERNEL_SIZE(3), .WORD_SIZE(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pix_valid(pv_a), .pix_ready(pr_a),
        .pix_data(pix_data), .window(win_a), .conv_ans(ans_a), .out_valid(ov_a),
        .out_ready(out_ready), .out_data(od_a), .out_x(ox_a), .out_y(oy_a),
        .busy(busy_a), .done(done_a));

    conv_window_controller #(.KERNEL_SIZE(3), .WORD_SIZE(16), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pix_valid(pv_b), .pix_ready(pr_b),
        .pix_data(pix_data), .window(win_b), .conv_ans(ans_b), .out_valid(ov_b),
        .out_ready(out_ready), .out_data(od_b), .out_x(ox_b), .out_y(oy_b),
        .busy(busy_b), .done(done_b));

    conv_window_controller #(.KERNEL_SIZE(3), .WORD_SIZE(16), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .pix_valid(pv_c), .pix_ready(pr_c),
        .pix_data(pix_data), .window(win_c), .conv_ans(ans_c), .out_valid(ov_c),
        .out_ready(out_ready), .out_data(od_c), .out_x(ox_c), .out_y(oy_c),
        .busy(busy_c), .done(done_c));

    // Outputs of the currently selected instance.
    logic               m_pr, m_ov, m_dn, m_bz;
    logic signed [15:0] m_od;
    int                 m_ox, m_oy;
    always_comb begin
        m_pr = 1'b0; m_ov = 1'b0; m_dn = 1'b0; m_bz = 1'b0; m_od = '0; m_ox = 0; m_oy = 0;
        case (sel)
            0: begin m_pr = pr_a; m_ov = ov_a; m_dn = done_a; m_bz = busy_a; m_od = od_a; m_ox = int'(ox_a); m_oy = int'(oy_a); end
            1: begin m_pr = pr_b; m_ov = ov_b; m_dn = done_b; m_bz = busy_b; m_od = od_b; m_ox = int'(ox_b); m_oy = int'(oy_b); end
            default: begin m_pr = pr_c; m_ov = ov_c; m_dn = done_c; m_bz = busy_c; m_od = od_c; m_ox = int'(ox_c); m_oy = int'(oy_c); end
        endcase
    end

    int n_pass = 0;
    int n_total = 0;

    int img [64];
    int acc_cyc [64];
    int first_ov_cyc;
    int obs_d[$], obs_x[$], obs_y[$];
    int exp_d[$], exp_x[$], exp_y[$];

    // Reference: every window whose bottom-right pixel has x,y >= K-1, in raster order.
    task automatic build_expected(input int w, input int h, input int mode);
        logic signed [15:0] t;
        int s;
        exp_d.delete(); exp_x.delete(); exp_y.delete();
        for (int y = K - 1; y < h; y++) begin
            for (int x = K - 1; x < w; x++) begin
                s = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += kern_w(mode, i, j) * img[(y - K + 1 + i) * w + (x - K + 1 + j)];
                t = 16'(s);
                exp_d.push_back(int'(t));
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
        end
    endtask

    // Drives one frame into the selected instance and records every output transfer.
    task automatic run_frame(input int w, input int h, input int vpct, input int rmode,
                             input int abort_after, input bit poke_start,
                             output int viol, output bit tmo, output int done_cnt);
        int idx, last_cyc, hx, hy;
        bit held;
        logic signed [15:0] hd;
        idx = 0; last_cyc = -10; held = 1'b0; hd = '0; hx = 0; hy = 0;
        viol = 0; tmo = 1'b1; done_cnt = 0; first_ov_cyc = -1;
        obs_d.delete(); obs_x.delete(); obs_y.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pix_valid = (idx < w * h) && ($urandom_range(0, 99) < vpct);
            pix_data  = 16'(img[(idx < w * h) ? idx : 0]);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 99) < 60);
            endcase
            start = poke_start && (cyc == 4 || cyc == 9);
            @(negedge clk);
            if (m_dn) begin
                done_cnt++;
                if (cyc != last_cyc + 1) viol++;
            end
            if (cyc == last_cyc + 2) begin
                if (m_bz) viol++;
                tmo = 1'b0;
                break;
            end
            if (!m_bz) viol++;
            if (held && (m_od !== hd || m_ox != hx || m_oy != hy || !m_ov)) viol++;
            if (m_ov && !out_ready) begin
                if (m_pr) viol++;
                held = 1'b1; hd = m_od; hx = m_ox; hy = m_oy;
            end else begin
                held = 1'b0;
            end
            if (m_ov && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (m_ov && out_ready) begin
                obs_d.push_back(int'(m_od));
                obs_x.push_back(m_ox);
                obs_y.push_back(m_oy);
                if (m_ox == w - 1 && m_oy == h - 1) last_cyc = cyc;
            end
            if (pix_valid && m_pr) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            if (abort_after >= 0 && idx == abort_after) begin
                @(posedge clk); #1;
                pix_valid = 1'b0;
                start = 1'b0;
                tmo = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (m_ov !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", m_ov); else n_pass++;
        n_total++; if (m_dn !== 1'b0) $display("FAIL reset_done got=%b want=0", m_dn); else n_pass++;
        n_total++; if (m_bz !== 1'b0) $display("FAIL reset_busy got=%b want=0", m_bz); else n_pass++;
        n_total++; if (m_pr !== 1'b0) $display("FAIL reset_pix_ready got=%b want=0", m_pr); else n_pass++;
        n_total++; if (m_od !== 16'sd0) $display("FAIL reset_out_data got=%0d want=0", m_od); else n_pass++;
        n_total++; if (win_a !== '0) $display("FAIL reset_window got=%h want=0", win_a); else n_pass++;
        n_total++; if (m_ox != 0 || m_oy != 0) $display("FAIL reset_xy got=(%0d,%0d) want=(0,0)", m_ox, m_oy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++; if (m_pr !== 1'b0 || m_bz !== 1'b0) $display("FAIL idle_after_reset ready=%b busy=%b want=0,0", m_pr, m_bz); else n_pass++;
    endtask

    task automatic test_basic(input string tag, input int rmode);
        int viol, dcnt;
        bit tmo;
        int cd[4] = '{18, 27, 27, 36};
        int cx[4] = '{2, 3, 2, 3};
        int cy[4] = '{2, 2, 3, 3};
        sel = 0; kmode_a = 0;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y * 4 + x] = x + y;
        run_frame(4, 4, 100, rmode, -1, 1'b0, viol, tmo, dcnt);
        n_total++; if (tmo) $display("FAIL %s_timeout frame did not complete", tag); else n_pass++;
        n_total++; if (obs_d.size() != 4) $display("FAIL %s_count got=%0d want=4", tag, obs_d.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            n_total++;
            if (obs_d[i] != cd[i] || obs_x[i] != cx[i] || obs_y[i] != cy[i])
                $display("FAIL %s_out%0d got=%0d@(%0d,%0d) want=%0d@(%0d,%0d)", tag, i,
                         obs_d[i], obs_x[i], obs_y[i], cd[i], cx[i], cy[i]);
            else n_pass++;
        end
        n_total++; if (dcnt != 1) $display("FAIL %s_done_pulses got=%0d want=1", tag, dcnt); else n_pass++;
        n_total++; if (viol != 0) $display("FAIL %s_protocol violations got=%0d want=0", tag, viol); else n_pass++;
        if (rmode == 0) begin
            n_total++;
            if (first_ov_cyc != acc_cyc[10] + 2)
                $display("FAIL %s_latency got=%0d want=%0d", tag, first_ov_cyc, acc_cyc[10] + 2);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int viol, dcnt, low_x;
        bit tmo;
        sel = 1; kmode_b = 2;
        for (int i = 0; i < 15; i++) img[i] = int'($urandom_range(0, 2000)) - 1000;
        build_expected(5, 3, 2);
        run_frame(5, 3, 50, 0, -1, 1'b0, viol, tmo, dcnt);
        n_total++; if (tmo) $display("FAIL wrap_timeout frame did not complete"); else n_pass++;
        n_total++; if (obs_d.size() != 3) $display("FAIL wrap_count got=%0d want=3", obs_d.size()); else n_pass++;
        low_x = 0;
        foreach (obs_x[i]) if (obs_x[i] < 2) low_x++;
        n_total++; if (low_x != 0) $display("FAIL wrap_suppressed got=%0d want=0", low_x); else n_pass++;
        for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
            n_total++;
            if (obs_d[i] != exp_d[i] || obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i])
                $display("FAIL wrap_out%0d got=%0d@(%0d,%0d) want=%0d@(%0d,%0d)", i,
                         obs_d[i], obs_x[i], obs_y[i], exp_d[i], exp_x[i], exp_y[i]);
            else n_pass++;
        end
        n_total++; if (dcnt != 1 || viol != 0) $display("FAIL wrap_done done=%0d viol=%0d want=1,0", dcnt, viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int viol, dcnt;
        bit tmo;
        sel = 0; kmode_a = 0;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y * 4 + x] = x + y;
        run_frame(4, 4, 100, 0, 7, 1'b0, viol, tmo, dcnt);
        n_total++; if (m_bz !== 1'b1) $display("FAIL midreset_busy_before got=%b want=1", m_bz); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (m_ov !== 1'b0 || m_bz !== 1'b0) $display("FAIL midreset_immediate valid=%b busy=%b want=0,0", m_ov, m_bz); else n_pass++;
        n_total++; if (m_dn !== 1'b0 || obs_d.size() != 0) $display("FAIL midreset_no_output done=%b outs=%0d want=0,0", m_dn, obs_d.size()); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        test_basic("rerun", 0);
    endtask

    task automatic test_start_in_run();
        int viol, dcnt;
        bit tmo;
        sel = 0; kmode_a = 0;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y * 4 + x] = x + y;
        run_frame(4, 4, 100, 0, -1, 1'b1, viol, tmo, dcnt);
        n_total++; if (tmo) $display("FAIL start_run_timeout frame did not complete"); else n_pass++;
        n_total++; if (obs_d.size() != 4) $display("FAIL start_run_count got=%0d want=4", obs_d.size()); else n_pass++;
        n_total++; if (viol != 0 || dcnt != 1) $display("FAIL start_run_busy viol=%0d done=%0d want=0,1", viol, dcnt); else n_pass++;
        @(negedge clk);
        n_total++; if (m_bz !== 1'b0) $display("FAIL start_run_idle busy got=%b want=0", m_bz); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_centre();
        int viol, dcnt;
        bit tmo;
        sel = 2; kmode_c = 1;
        for (int i = 0; i < 9; i++) img[i] = 100;
        run_frame(3, 3, 100, 0, -1, 1'b0, viol, tmo, dcnt);
        n_total++; if (tmo) $display("FAIL centre_timeout frame did not complete"); else n_pass++;
        n_total++; if (obs_d.size() != 1) $display("FAIL centre_count got=%0d want=1", obs_d.size()); else n_pass++;
        if (obs_d.size() > 0) begin
            n_total++;
            if (obs_d[0] != 100 || obs_x[0] != 2 || obs_y[0] != 2)
                $display("FAIL centre_out got=%0d@(%0d,%0d) want=100@(2,2)", obs_d[0], obs_x[0], obs_y[0]);
            else n_pass++;
        end
        n_total++; if (dcnt != 1 || viol != 0) $display("FAIL centre_done done=%0d viol=%0d want=1,0", dcnt, viol); else n_pass++;
        @(negedge clk);
        n_total++; if (m_bz !== 1'b0 || m_pr !== 1'b0) $display("FAIL centre_idle busy=%b ready=%b want=0,0", m_bz, m_pr); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int viol, dcnt, w, h, bad;
        bit tmo;
        for (int f = 0; f < 6; f++) begin
            sel = f % 2;
            w = (sel == 0) ? 4 : 5;
            h = (sel == 0) ? 4 : 3;
            kmode_a = 2; kmode_b = 2;
            for (int i = 0; i < w * h; i++) img[i] = int'($urandom_range(0, 65535)) - 32768;
            build_expected(w, h, 2);
            run_frame(w, h, 70, 2, -1, 1'b0, viol, tmo, dcnt);
            n_total++;
            if (tmo || viol != 0 || dcnt != 1)
                $display("FAIL b2b%0d_protocol tmo=%0d viol=%0d done=%0d want=0,0,1", f, tmo, viol, dcnt);
            else n_pass++;
            n_total++;
            if (obs_d.size() != exp_d.size())
                $display("FAIL b2b%0d_count got=%0d want=%0d", f, obs_d.size(), exp_d.size());
            else n_pass++;
            bad = 0;
            for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++)
                if (obs_d[i] != exp_d[i] || obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i]) begin
                    if (bad == 0)
                        $display("FAIL b2b%0d_out%0d got=%0d@(%0d,%0d) want=%0d@(%0d,%0d)", f, i,
                                 obs_d[i], obs_x[i], obs_y[i], exp_d[i], exp_x[i], exp_y[i]);
                    bad++;
                end
            n_total++;
            if (bad == 0) n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; out_ready = 1'b1; pix_data = '0;
        sel = 0; kmode_a = 0; kmode_b = 0; kmode_c = 1;
        test_reset();
        test_basic("basic", 0);
        test_basic("stall", 1);
        test_wrap();
        test_reset_mid();
        test_start_in_run();
        test_centre();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
